// File: rtl/mem_ctrl_if.sv
// Bundle of every mem_ctrl signal except clock and reset: RAM/IO bus, i-cache refill, LSB port.
// Latency: none, wires only.
// Backpressure: none here; requests are level-held until their done pulse, rdy freezes the controller.
// Ports: master = mem_ctrl side (drives RAM bus and responses), slave = clients/RAM side.
interface mem_ctrl_if #(
    parameter int LINE_BYTES = 64
) ();
    logic                    rdy;
    logic [7:0]              mem_din;
    logic [7:0]              mem_dout;
    logic [31:0]             mem_a;
    logic                    mem_wr;
    logic                    io_buffer_full;
    logic [31:0]             missing_PC;
    logic                    missing_config;
    logic [8*LINE_BYTES-1:0] return_row;
    logic                    return_config;
    logic                    lsb_valid;
    logic                    lsb_wr;
    logic [31:0]             lsb_addr;
    logic [1:0]              lsb_size;
    logic                    lsb_signed;
    logic [31:0]             lsb_wdata;
    logic [31:0]             lsb_rdata;
    logic                    lsb_done;
    logic                    rollback;

    modport master (
        input  rdy, mem_din, io_buffer_full, missing_PC, missing_config,
               lsb_valid, lsb_wr, lsb_addr, lsb_size, lsb_signed, lsb_wdata, rollback,
        output mem_dout, mem_a, mem_wr, return_row, return_config, lsb_rdata, lsb_done
    );

    modport slave (
        output rdy, mem_din, io_buffer_full, missing_PC, missing_config,
               lsb_valid, lsb_wr, lsb_addr, lsb_size, lsb_signed, lsb_wdata, rollback,
        input  mem_dout, mem_a, mem_wr, return_row, return_config, lsb_rdata, lsb_done
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-wide RAM/IO bus owner: serialises i-cache line refills and LSB loads/stores into byte cycles.
// Latency: load done n+2 cycles after accept, refill pulse 66 cycles after accept, store n+2 when unstalled.
// Backpressure: requests are level-held; rdy=0 freezes everything; IO stores stall while io_buffer_full.
// Ports: clk, rst (async active-low), bus (mem_ctrl_if.master: RAM bus, refill port, LSB port, rdy, rollback).
module mem_ctrl #(
    parameter int          LINE_BYTES = 64,
    parameter logic [31:0] IO_BASE    = 32'h30000
) (
    input  logic       clk,
    input  logic       rst,
    mem_ctrl_if.master bus
);
    localparam int OFS_W = $clog2(LINE_BYTES);
    localparam int CNT_W = OFS_W + 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] IFETCH = 3'd1;
    localparam logic [2:0] LOAD   = 3'd2;
    localparam logic [2:0] STORE  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      base;
    logic [1:0]       size;
    logic             sgn;
    logic [31:0]      wdata;
    logic [31:0]      ld_buf;
    logic             is_fetch;

    logic [CNT_W-1:0] nbytes;
    logic [31:0]      cur_addr;
    logic [31:0]      nxt_addr;
    logic             io_stall;
    logic             take_lsb;
    logic             quiet;
    logic [31:0]      ld_ext;

    assign cur_addr = base + 32'(cnt);
    assign nxt_addr = cur_addr + 32'd1;
    assign io_stall = (cur_addr >= IO_BASE) && bus.io_buffer_full;
    // A flush in the same cycle kills a load before it starts; stores are already committed.
    assign take_lsb = bus.lsb_valid && !(bus.rollback && !bus.lsb_wr);
    // While a done pulse is out, the requester may still be holding its level request.
    assign quiet    = !bus.lsb_done && !bus.return_config;

    always_comb begin
        nbytes = CNT_W'(4);
        if (size == 2'd0)
            nbytes = CNT_W'(1);
        else if (size == 2'd1)
            nbytes = CNT_W'(2);
    end

    always_comb begin
        ld_ext = ld_buf;
        if (size == 2'd0)
            ld_ext = {{24{sgn & ld_buf[7]}}, ld_buf[7:0]};
        else if (size == 2'd1)
            ld_ext = {{16{sgn & ld_buf[15]}}, ld_buf[15:0]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            cnt                <= '0;
            base               <= '0;
            size               <= '0;
            sgn                <= 1'b0;
            wdata              <= '0;
            ld_buf             <= '0;
            is_fetch           <= 1'b0;
            bus.mem_a          <= '0;
            bus.mem_wr         <= 1'b0;
            bus.mem_dout       <= '0;
            bus.return_row     <= '0;
            bus.return_config  <= 1'b0;
            bus.lsb_rdata      <= '0;
            bus.lsb_done       <= 1'b0;
        end else if (bus.rdy) begin
            bus.lsb_done      <= 1'b0;
            bus.return_config <= 1'b0;
            case (state)
                IDLE: begin
                    if (quiet && take_lsb) begin
                        base     <= bus.lsb_addr;
                        size     <= bus.lsb_size;
                        sgn      <= bus.lsb_signed;
                        wdata    <= bus.lsb_wdata;
                        ld_buf   <= '0;
                        is_fetch <= 1'b0;
                        cnt      <= '0;
                        if (bus.lsb_wr) begin
                            state <= STORE;
                        end else begin
                            state     <= LOAD;
                            bus.mem_a <= bus.lsb_addr;
                        end
                    end else if (quiet && bus.missing_config) begin
                        base      <= bus.missing_PC & ~32'(LINE_BYTES - 1);
                        bus.mem_a <= bus.missing_PC & ~32'(LINE_BYTES - 1);
                        is_fetch  <= 1'b1;
                        cnt       <= '0;
                        state     <= IFETCH;
                    end
                end
                // cnt counts bytes captured; the address for byte cnt is on the bus this cycle.
                IFETCH: begin
                    bus.return_row[{cnt[OFS_W-1:0], 3'b000} +: 8] <= bus.mem_din;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(LINE_BYTES - 1))
                        state <= DONE;
                    else
                        bus.mem_a <= nxt_addr;
                end
                LOAD: begin
                    if (bus.rollback) begin
                        state <= IDLE;
                    end else begin
                        ld_buf[{cnt[1:0], 3'b000} +: 8] <= bus.mem_din;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == nbytes - CNT_W'(1))
                            state <= DONE;
                        else
                            bus.mem_a <= nxt_addr;
                    end
                end
                // cnt counts bytes issued; a stalled IO byte is simply re-tried next cycle.
                STORE: begin
                    if (cnt == nbytes) begin
                        bus.mem_wr   <= 1'b0;
                        bus.lsb_done <= 1'b1;
                        state        <= IDLE;
                    end else if (io_stall) begin
                        bus.mem_wr <= 1'b0;
                    end else begin
                        bus.mem_a    <= cur_addr;
                        bus.mem_dout <= wdata[{cnt[1:0], 3'b000} +: 8];
                        bus.mem_wr   <= 1'b1;
                        cnt          <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (is_fetch) begin
                        bus.return_config <= 1'b1;
                    end else if (!bus.rollback) begin
                        bus.lsb_done  <= 1'b1;
                        bus.lsb_rdata <= ld_ext;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: table of LSB loads/stores plus hand sequences for refill,
// priority, IO stall, rollback, rdy freeze and asynchronous reset.
// Cycle k after an accept edge is sampled on the k-th falling edge following it.
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_ctrl_if #(.LINE_BYTES(64)) bus ();
    mem_ctrl #(.LINE_BYTES(64), .IO_BASE(32'h30000)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] ram [0:65535];
    int         wr_cnt    = 0;
    int         io_wr_cnt = 0;
    logic [7:0] io_last   = 8'h00;

    assign bus.mem_din = ram[bus.mem_a[15:0]];

    always @(posedge clk) begin
        if (rst && bus.rdy && bus.mem_wr) begin
            wr_cnt++;
            if (bus.mem_a >= 32'h30000) begin
                io_wr_cnt++;
                io_last = bus.mem_dout;
            end else begin
                ram[bus.mem_a[15:0]] <= bus.mem_dout;
            end
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    // Issue one LSB request, wait for lsb_done, check latency, data and write count.
    task automatic run_lsb(input vec_t v, input string tag);
        int n;
        int k_done;
        int w0;
        n = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
        @(posedge clk); #1;
        bus.lsb_valid  = 1'b1;
        bus.lsb_wr     = v.wr;
        bus.lsb_addr   = v.addr;
        bus.lsb_size   = v.size;
        bus.lsb_signed = v.sgn;
        bus.lsb_wdata  = v.wdata;
        w0     = wr_cnt;
        k_done = 0;
        for (int k = 1; k <= 40 && k_done == 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.lsb_done) k_done = k;
        end
        chk({tag, " latency"}, 512'(k_done), 512'(n + 2));
        if (v.wr)
            chk({tag, " writes"}, 512'(wr_cnt - w0), 512'(n));
        else
            chk({tag, " rdata"}, 512'(bus.lsb_rdata), 512'(v.exp));
        @(posedge clk); #1;
        bus.lsb_valid = 1'b0;
        @(negedge clk);
        chk({tag, " done width"}, 512'(bus.lsb_done), 512'(0));
    endtask

    vec_t            vecs [11];
    logic [511:0]    exp_row;
    int              walk_bad, rc_first, rc_cnt, ld_first, first_wr, wr_seen, done_first, done_seen;
    logic [31:0]     seen_a, seen_d;
    vec_t            bv;

    initial begin
        vecs[0]  = '{1'b0, 32'h00000005, 2'd0, 1'b1, 32'h0,        32'hFFFFFF80};
        vecs[1]  = '{1'b0, 32'h00000005, 2'd0, 1'b0, 32'h0,        32'h00000080};
        vecs[2]  = '{1'b0, 32'h00000100, 2'd2, 1'b0, 32'h0,        32'h03020100};
        vecs[3]  = '{1'b0, 32'h000001FE, 2'd1, 1'b1, 32'h0,        32'hFFFFFFFE};
        vecs[4]  = '{1'b0, 32'h00000181, 2'd1, 1'b0, 32'h0,        32'h00008281};
        vecs[5]  = '{1'b1, 32'h00000200, 2'd1, 1'b0, 32'h1234BEEF, 32'h0};
        vecs[6]  = '{1'b0, 32'h000001FF, 2'd2, 1'b0, 32'h0,        32'h02BEEFFF};
        vecs[7]  = '{1'b1, 32'h00000300, 2'd3, 1'b0, 32'hCAFEF00D, 32'h0};
        vecs[8]  = '{1'b0, 32'h00000300, 2'd3, 1'b1, 32'h0,        32'hCAFEF00D};
        vecs[9]  = '{1'b0, 32'h00000302, 2'd0, 1'b1, 32'h0,        32'hFFFFFFFE};
        vecs[10] = '{1'b0, 32'hFFFFFFFF, 2'd2, 1'b0, 32'h0,        32'h020100FF};

        for (int i = 0; i < 65536; i++) ram[i] = i[7:0];
        ram[5] = 8'h80;

        rst = 1'b0;
        bus.rdy = 1'b1; bus.io_buffer_full = 1'b0; bus.missing_PC = '0; bus.missing_config = 1'b0;
        bus.lsb_valid = 1'b0; bus.lsb_wr = 1'b0; bus.lsb_addr = '0; bus.lsb_size = '0;
        bus.lsb_signed = 1'b0; bus.lsb_wdata = '0; bus.rollback = 1'b0;
        #12;
        chk("reset mem_a", 512'(bus.mem_a), 512'(0));
        chk("reset mem_wr", 512'(bus.mem_wr), 512'(0));
        chk("reset lsb_done", 512'(bus.lsb_done), 512'(0));
        chk("reset return_config", 512'(bus.return_config), 512'(0));
        chk("reset return_row", bus.return_row, 512'(0));
        @(negedge clk); rst = 1'b1;

        // Line refill: address walk, pulse on cycle 66, line contents.
        @(posedge clk); #1;
        bus.missing_PC = 32'h1234; bus.missing_config = 1'b1;
        walk_bad = 0; rc_first = 0; rc_cnt = 0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (rc_first != 0) bus.missing_config = 1'b0;
            @(negedge clk);
            if (k <= 64 && (bus.mem_a !== 32'h1200 + 32'(k - 1) || bus.mem_wr !== 1'b0)) walk_bad++;
            if (bus.return_config) begin
                rc_cnt++;
                if (rc_first == 0) rc_first = k;
            end
        end
        for (int b = 0; b < 64; b++) exp_row[8*b +: 8] = 8'(b);
        chk("refill walk errors", 512'(walk_bad), 512'(0));
        chk("refill pulse cycle", 512'(rc_first), 512'(66));
        chk("refill pulse count", 512'(rc_cnt), 512'(1));
        chk("refill row", bus.return_row, exp_row);

        for (int i = 0; i < 11; i++) run_lsb(vecs[i], $sformatf("vec%0d", i));
        chk("store half byte0", 512'(ram[16'h200]), 512'(8'hEF));
        chk("store half byte1", 512'(ram[16'h201]), 512'(8'hBE));
        chk("store half untouched", 512'(ram[16'h202]), 512'(8'h02));

        // Store just below IO_BASE is not subject to the IO buffer.
        bus.io_buffer_full = 1'b1;
        bv = '{1'b1, 32'h0002FFFF, 2'd0, 1'b0, 32'h0000005A, 32'h0};
        run_lsb(bv, "below_io");
        bus.io_buffer_full = 1'b0;
        chk("below_io ram", 512'(ram[16'hFFFF]), 512'(8'h5A));
        chk("below_io no io write", 512'(io_wr_cnt), 512'(0));

        // Load and refill in the same cycle: load first, refill after the idle cycle.
        @(posedge clk); #1;
        bus.lsb_valid = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_addr = 32'h100; bus.lsb_size = 2'd2;
        bus.lsb_signed = 1'b0; bus.missing_PC = 32'h2040; bus.missing_config = 1'b1;
        ld_first = 0; rc_first = 0; seen_d = '0;
        for (int k = 1; k <= 90; k++) begin
            @(posedge clk); #1;
            if (ld_first != 0) bus.lsb_valid = 1'b0;
            if (rc_first != 0) bus.missing_config = 1'b0;
            @(negedge clk);
            if (bus.lsb_done && ld_first == 0) begin ld_first = k; seen_d = bus.lsb_rdata; end
            if (bus.return_config && rc_first == 0) rc_first = k;
        end
        for (int b = 0; b < 64; b++) exp_row[8*b +: 8] = 8'(8'h40 + b);
        chk("prio load cycle", 512'(ld_first), 512'(6));
        chk("prio load rdata", 512'(seen_d), 512'(32'h03020100));
        chk("prio refill cycle", 512'(rc_first), 512'(73));
        chk("prio refill row", bus.return_row, exp_row);

        // IO store held off by io_buffer_full for five cycles.
        @(posedge clk); #1;
        bus.lsb_valid = 1'b1; bus.lsb_wr = 1'b1; bus.lsb_addr = 32'h30000; bus.lsb_size = 2'd0;
        bus.lsb_wdata = 32'h000000A5; bus.io_buffer_full = 1'b1;
        first_wr = 0; wr_seen = 0; done_first = 0;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            if (k == 6) bus.io_buffer_full = 1'b0;
            if (done_first != 0) bus.lsb_valid = 1'b0;
            @(negedge clk);
            if (bus.mem_wr) begin
                wr_seen++;
                if (first_wr == 0) first_wr = k;
            end
            if (bus.lsb_done && done_first == 0) done_first = k;
        end
        chk("io first write cycle", 512'(first_wr), 512'(7));
        chk("io write cycles", 512'(wr_seen), 512'(1));
        chk("io done cycle", 512'(done_first), 512'(8));
        chk("io data", 512'(io_last), 512'(8'hA5));

        // Rollback during a word load: no completion, address walk stops.
        @(posedge clk); #1;
        bus.lsb_valid = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_addr = 32'h100; bus.lsb_size = 2'd2;
        done_seen = 0; seen_a = '0;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            if (k == 3) begin bus.rollback = 1'b1; bus.lsb_valid = 1'b0; end
            if (k == 4) bus.rollback = 1'b0;
            @(negedge clk);
            if (k == 4) seen_a = bus.mem_a;
            if (bus.lsb_done) done_seen++;
        end
        chk("rollback mem_a", 512'(seen_a), 512'(32'h102));
        chk("rollback no done", 512'(done_seen), 512'(0));

        // Rollback in IDLE blocks a same-cycle load for that cycle only.
        @(posedge clk); #1;
        bus.lsb_valid = 1'b1; bus.lsb_addr = 32'h5; bus.lsb_size = 2'd0; bus.lsb_signed = 1'b0;
        bus.rollback = 1'b1;
        done_first = 0; seen_d = '0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 1) bus.rollback = 1'b0;
            if (done_first != 0) bus.lsb_valid = 1'b0;
            @(negedge clk);
            if (bus.lsb_done && done_first == 0) begin done_first = k; seen_d = bus.lsb_rdata; end
        end
        chk("idle rollback delay", 512'(done_first), 512'(4));
        chk("idle rollback rdata", 512'(seen_d), 512'(32'h80));

        // rdy low for three edges mid-load stretches latency without corrupting data.
        @(posedge clk); #1;
        bus.lsb_valid = 1'b1; bus.lsb_addr = 32'h100; bus.lsb_size = 2'd2;
        done_first = 0; seen_d = '0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 2) bus.rdy = 1'b0;
            if (k == 5) bus.rdy = 1'b1;
            if (done_first != 0) bus.lsb_valid = 1'b0;
            @(negedge clk);
            if (bus.lsb_done && done_first == 0) begin done_first = k; seen_d = bus.lsb_rdata; end
        end
        chk("freeze done cycle", 512'(done_first), 512'(9));
        chk("freeze rdata", 512'(seen_d), 512'(32'h03020100));

        // Asynchronous reset in the middle of a refill.
        @(posedge clk); #1;
        bus.missing_PC = 32'h1234; bus.missing_config = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b0; bus.missing_config = 1'b0;
        #1;
        chk("async rst mem_a", 512'(bus.mem_a), 512'(0));
        chk("async rst mem_dout", 512'(bus.mem_dout), 512'(0));
        chk("async rst lsb_rdata", 512'(bus.lsb_rdata), 512'(0));
        chk("async rst return_row", bus.return_row, 512'(0));
        #20; rst = 1'b1;
        rc_cnt = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (bus.return_config) rc_cnt++;
        end
        chk("async rst no pulse", 512'(rc_cnt), 512'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
